xadc_drp_responder: RTL and testbench

- Synthesizable DRP responder (slave) that emulates the XADC read port from the FPGA side.
- Accepts voltage and current samples on two 16-bit AXI-Stream sinks and runs an emulated two-channel conversion sequence.
- Holds the converted results in status registers and serves them to a DRP initiator such as xadc_drp_axis_adapter.
- Drives eoc/eos/busy/channel exactly as the adapter expects; used for hardware-in-loop replay and adapter bring-up without the XADC primitive.

---
 rtl/xadc_drp_responder_if.sv | 11 +
 rtl/xadc_drp_responder.sv | 191 +++++++++++++++++++
 tb/tb_xadc_drp_responder.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xadc_drp_responder_if.sv
// AXI-Stream style sample channel used by the XADC DRP responder.
interface axis_io #(
  parameter int unsigned W = 16
) ();
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport Sink   (input tdata, input tvalid, output tready);
  modport Source (output tdata, output tvalid, input tready);
endinterface

// File: rtl/xadc_drp_responder.sv
// DRP slave emulating the XADC read port: ingests voltage/current samples,
// runs a two-channel conversion sequence and serves the results over DRP.
module xadc_drp_responder #(
  parameter logic [6:0]  VOLTAGE_ADDR = 7'h14,
  parameter logic [6:0]  CURRENT_ADDR = 7'h1C,
  parameter int unsigned CONV_CYCLES  = 26,
  parameter int unsigned READ_LATENCY = 4
) (
  input  logic        xadc_dclk,
  input  logic        xadc_reset,
  axis_io.Sink        voltage_channel,
  axis_io.Sink        current_monitor_channel,
  input  logic [6:0]  xadc_daddr,
  input  logic        xadc_den,
  input  logic        xadc_dwe,
  input  logic [15:0] xadc_di,
  output logic        xadc_drdy,
  output logic [15:0] xadc_do,
  output logic [4:0]  xadc_channel,
  output logic        xadc_eoc,
  output logic        xadc_eos,
  output logic        xadc_busy,
  output logic        drp_error
);

  localparam int unsigned CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam int unsigned LAT_W = $clog2(READ_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_CYCLES - 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY - 1);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV_V,
    S_EOC_V,
    S_CONV_I,
    S_EOC_I
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             commit_v, commit_i;
  logic             busy_d, eoc_d, eos_d;
  logic [4:0]       channel_d;

  logic [15:0] v_pend, i_pend, v_stat, i_stat;
  logic        v_full, i_full;
  logic        v_beat, i_beat;

  logic [LAT_W-1:0] lat_q;
  logic             wr_q;
  logic [15:0]      data_q;
  logic [15:0]      rd_data;
  logic             outstanding, accept, collide;
  logic             unused_di;

  assign unused_di = ^xadc_di;

  // Ingest: one pending slot per channel, refilled once its value is committed.
  assign voltage_channel.tready         = !xadc_reset && !v_full;
  assign current_monitor_channel.tready = !xadc_reset && !i_full;
  assign v_beat = voltage_channel.tvalid && voltage_channel.tready;
  assign i_beat = current_monitor_channel.tvalid && current_monitor_channel.tready;

  always_ff @(posedge xadc_dclk) begin
    if (xadc_reset) begin
      v_pend <= '0;
      i_pend <= '0;
      v_full <= 1'b0;
      i_full <= 1'b0;
      v_stat <= '0;
      i_stat <= '0;
    end else begin
      if (v_beat) begin
        v_pend <= voltage_channel.tdata;
        v_full <= 1'b1;
      end else if (commit_v) begin
        v_full <= 1'b0;
      end
      if (i_beat) begin
        i_pend <= current_monitor_channel.tdata;
        i_full <= 1'b1;
      end else if (commit_i) begin
        i_full <= 1'b0;
      end
      if (commit_v) v_stat <= v_pend;
      if (commit_i) i_stat <= i_pend;
    end
  end

  // Conversion sequencer state register and registered status outputs.
  always_ff @(posedge xadc_dclk) begin
    if (xadc_reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      xadc_busy    <= 1'b0;
      xadc_eoc     <= 1'b0;
      xadc_eos     <= 1'b0;
      xadc_channel <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      xadc_busy    <= busy_d;
      xadc_eoc     <= eoc_d;
      xadc_eos     <= eos_d;
      xadc_channel <= channel_d;
    end
  end

  // Outputs are computed from the next state so they line up with the state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    commit_v  = 1'b0;
    commit_i  = 1'b0;
    busy_d    = 1'b0;
    eoc_d     = 1'b0;
    eos_d     = 1'b0;
    channel_d = xadc_channel;
    case (state_q)
      S_IDLE: begin
        if (v_full && i_full) state_d = S_CONV_V;
      end
      S_CONV_V: begin
        if (cnt_q == CNT_LAST) begin
          commit_v = 1'b1;
          state_d  = S_EOC_V;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EOC_V: state_d = S_CONV_I;
      S_CONV_I: begin
        if (cnt_q == CNT_LAST) begin
          commit_i = 1'b1;
          state_d  = S_EOC_I;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EOC_I: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_CONV_V) || (state_d == S_CONV_I);
    eoc_d  = (state_d == S_EOC_V) || (state_d == S_EOC_I);
    eos_d  = (state_d == S_EOC_I);
    if (state_d == S_CONV_V) channel_d = VOLTAGE_ADDR[4:0];
    if (state_d == S_CONV_I) channel_d = CURRENT_ADDR[4:0];
  end

  // DRP: data is captured at den, so a read racing a commit sees the old value.
  always_comb begin
    rd_data = '0;
    if (xadc_daddr == VOLTAGE_ADDR)      rd_data = v_stat;
    else if (xadc_daddr == CURRENT_ADDR) rd_data = i_stat;
  end

  assign outstanding = (lat_q != '0);
  assign accept      = xadc_den && !outstanding;
  assign collide     = xadc_den && outstanding;

  always_ff @(posedge xadc_dclk) begin
    if (xadc_reset) begin
      lat_q     <= '0;
      wr_q      <= 1'b0;
      data_q    <= '0;
      xadc_drdy <= 1'b0;
      xadc_do   <= '0;
      drp_error <= 1'b0;
    end else begin
      xadc_drdy <= 1'b0;
      if (collide) drp_error <= 1'b1;
      if (accept) begin
        wr_q   <= xadc_dwe;
        data_q <= rd_data;
        lat_q  <= LAT_LOAD;
        if (READ_LATENCY == 1) begin
          xadc_drdy <= 1'b1;
          if (!xadc_dwe) xadc_do <= rd_data;
        end
      end else if (outstanding) begin
        lat_q <= lat_q - 1'b1;
        if (lat_q == LAT_ONE) begin
          xadc_drdy <= 1'b1;
          if (!wr_q) xadc_do <= data_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_xadc_drp_responder.sv
// Scoreboard bench for xadc_drp_responder: stimulus queues expectations,
// a negedge monitor checks DRP responses, conversion pulses and probes.
module tb_xadc_drp_responder;

  localparam logic [6:0] VA  = 7'h14;
  localparam logic [6:0] CA  = 7'h1C;
  localparam int         LAT = 4;

  localparam int P_BUSY = 0, P_CHAN = 1, P_EOC = 2, P_EOS = 3, P_DRDY = 4,
                 P_DO = 5, P_ERR = 6, P_TRV = 7, P_TRI = 8, P_DRPQ = 9, P_EOCQ = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  daddr;
  logic        den, dwe;
  logic [15:0] di;
  logic        drdy, eoc, eos, busy, drp_error;
  logic [15:0] dout;
  logic [4:0]  channel;

  axis_io #(.W(16)) vch ();
  axis_io #(.W(16)) ich ();

  xadc_drp_responder dut (
    .xadc_dclk               (clk),
    .xadc_reset              (rst),
    .voltage_channel         (vch),
    .current_monitor_channel (ich),
    .xadc_daddr              (daddr),
    .xadc_den                (den),
    .xadc_dwe                (dwe),
    .xadc_di                 (di),
    .xadc_drdy               (drdy),
    .xadc_do                 (dout),
    .xadc_channel            (channel),
    .xadc_eoc                (eoc),
    .xadc_eos                (eos),
    .xadc_busy               (busy),
    .drp_error               (drp_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [15:0] data; } drp_exp_t;
  typedef struct { int cyc; logic [4:0] ch; logic eos; } eoc_exp_t;
  typedef struct { int cyc; int sel; logic [15:0] exp; } probe_t;

  drp_exp_t drp_q[$];
  eoc_exp_t eoc_q[$];
  probe_t   probe_q[$];

  int n_vec = 0;
  int n_err = 0;

  function automatic string probe_name(input int sel);
    case (sel)
      P_BUSY:  return "busy";
      P_CHAN:  return "channel";
      P_EOC:   return "eoc";
      P_EOS:   return "eos";
      P_DRDY:  return "drdy";
      P_DO:    return "do";
      P_ERR:   return "drp_error";
      P_TRV:   return "voltage_tready";
      P_TRI:   return "current_tready";
      P_DRPQ:  return "drp_responses_outstanding";
      default: return "eoc_events_outstanding";
    endcase
  endfunction

  function automatic logic [15:0] probe_val(input int sel);
    case (sel)
      P_BUSY:  return 16'(busy);
      P_CHAN:  return 16'(channel);
      P_EOC:   return 16'(eoc);
      P_EOS:   return 16'(eos);
      P_DRDY:  return 16'(drdy);
      P_DO:    return dout;
      P_ERR:   return 16'(drp_error);
      P_TRV:   return 16'(vch.tready);
      P_TRI:   return 16'(ich.tready);
      P_DRPQ:  return 16'(drp_q.size());
      default: return 16'(eoc_q.size());
    endcase
  endfunction

  drp_exp_t    m_d;
  eoc_exp_t    m_e;
  probe_t      m_p;
  logic [15:0] m_act;

  // Monitor: sole owner of the comparison counters.
  always @(negedge clk) begin
    if (drdy === 1'b1) begin
      n_vec++;
      if (drp_q.size() == 0) begin
        n_err++;
        $display("FAIL drdy_unexpected: cyc %0d got drdy do=%h, required no drdy", cyc, dout);
      end else begin
        m_d = drp_q.pop_front();
        if (m_d.cyc != cyc || m_d.data !== dout) begin
          n_err++;
          $display("FAIL drp_response: got cyc %0d do=%h, required cyc %0d do=%h",
                   cyc, dout, m_d.cyc, m_d.data);
        end
      end
    end
    if (eoc === 1'b1 || eos === 1'b1) begin
      n_vec++;
      if (eoc_q.size() == 0) begin
        n_err++;
        $display("FAIL eoc_unexpected: cyc %0d eoc=%b eos=%b ch=%h, required none", cyc, eoc, eos, channel);
      end else begin
        m_e = eoc_q.pop_front();
        if (m_e.cyc != cyc || eoc !== 1'b1 || m_e.ch !== channel || m_e.eos !== eos) begin
          n_err++;
          $display("FAIL eoc_event: got cyc %0d eoc=%b eos=%b ch=%h, required cyc %0d eoc=1 eos=%b ch=%h",
                   cyc, eoc, eos, channel, m_e.cyc, m_e.eos, m_e.ch);
        end
      end
    end
    while (probe_q.size() > 0 && probe_q[0].cyc <= cyc) begin
      m_p   = probe_q.pop_front();
      m_act = probe_val(m_p.sel);
      n_vec++;
      if (m_p.cyc != cyc || m_act !== m_p.exp) begin
        n_err++;
        $display("FAIL %s: cyc %0d got %h, required %h at cyc %0d",
                 probe_name(m_p.sel), cyc, m_act, m_p.exp, m_p.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic probe(input int t, input int sel, input logic [15:0] v);
    probe_t p;
    int     i;
    p.cyc = t;
    p.sel = sel;
    p.exp = v;
    i = probe_q.size();
    while (i > 0 && probe_q[i-1].cyc > t) i--;
    probe_q.insert(i, p);
  endtask

  task automatic reset_probes(input int t);
    for (int s = P_BUSY; s <= P_TRI; s++) probe(t, s, 16'h0000);
  endtask

  // Presents one beat and returns the clock count of the accepting edge.
  task automatic push(input bit cur, input logic [15:0] d, output int m);
    int k;
    k = 0;
    if (cur) begin ich.tdata = d; ich.tvalid = 1'b1; end
    else     begin vch.tdata = d; vch.tvalid = 1'b1; end
    @(negedge clk);
    while (!(cur ? ich.tready : vch.tready)) begin
      k++;
      if (k > 200) begin
        $display("FAIL push_timeout: tready stayed 0 for 200 clocks, required 1");
        $fatal(1);
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    m = cyc;
    if (cur) ich.tvalid = 1'b0;
    else     vch.tvalid = 1'b0;
  endtask

  task automatic drp(input logic [6:0] a, input logic we, input logic [15:0] d,
                     input bit expect_rdy, input logic [15:0] exp);
    drp_exp_t e;
    e.cyc  = cyc + LAT;
    e.data = exp;
    daddr = a;
    den   = 1'b1;
    dwe   = we;
    di    = d;
    if (expect_rdy) drp_q.push_back(e);
    step();
    den = 1'b0;
    dwe = 1'b0;
    di  = 16'h0000;
  endtask

  task automatic expect_eoc(input int t, input logic [4:0] ch, input logic s);
    eoc_exp_t e;
    e.cyc = t;
    e.ch  = ch;
    e.eos = s;
    eoc_q.push_back(e);
  endtask

  // Full sequence starting at the edge that completed the sample pair.
  task automatic expect_seq(input int m);
    expect_eoc(m + 27, VA[4:0], 1'b0);
    expect_eoc(m + 54, CA[4:0], 1'b1);
    probe(m,      P_BUSY, 16'h0);
    probe(m + 1,  P_BUSY, 16'h1);
    probe(m + 1,  P_CHAN, 16'h14);
    probe(m + 27, P_BUSY, 16'h0);
    probe(m + 28, P_BUSY, 16'h1);
    probe(m + 28, P_CHAN, 16'h1C);
    probe(m + 55, P_BUSY, 16'h0);
    probe(m + 55, P_CHAN, 16'h1C);
  endtask

  initial begin
    int m, mv, n;
    rst = 1'b1;
    daddr = '0; den = 1'b0; dwe = 1'b0; di = '0;
    vch.tdata = '0; vch.tvalid = 1'b0;
    ich.tdata = '0; ich.tvalid = 1'b0;

    // reset values
    wait_until(2);
    reset_probes(2);
    step();
    rst = 1'b0;
    probe(cyc, P_TRV, 16'h1);
    probe(cyc, P_TRI, 16'h1);

    // first sequence
    push(1'b0, 16'hABC0, mv);
    probe(mv, P_TRV, 16'h0);
    probe(mv, P_TRI, 16'h1);
    push(1'b1, 16'h1230, m);
    probe(m, P_TRV, 16'h0);
    probe(m, P_TRI, 16'h0);
    expect_seq(m);
    wait_until(m + 56);

    // reads, den on the drdy cycle, write, unmapped address
    n = cyc;
    drp(VA, 1'b0, 16'h0, 1'b1, 16'hABC0);
    wait_until(n + LAT);
    drp(CA, 1'b0, 16'h0, 1'b1, 16'h1230);
    wait_until(n + 2 * LAT + 2);
    n = cyc;
    drp(VA, 1'b1, 16'hFFFF, 1'b1, 16'h1230);
    wait_until(n + LAT + 1);
    n = cyc;
    drp(VA, 1'b0, 16'h0, 1'b1, 16'hABC0);
    wait_until(n + LAT + 1);
    n = cyc;
    drp(7'h00, 1'b0, 16'h0, 1'b1, 16'h0000);
    probe(n + LAT + 1, P_ERR, 16'h0);
    wait_until(n + LAT + 2);

    // read racing the voltage commit, then the read after it
    push(1'b0, 16'h5550, mv);
    push(1'b1, 16'hBEE0, m);
    expect_seq(m);
    probe(m + 26, P_TRV, 16'h0);
    probe(m + 27, P_TRV, 16'h1);
    probe(m + 27, P_TRI, 16'h0);
    wait_until(m + 26);
    drp(VA, 1'b0, 16'h0, 1'b1, 16'hABC0);
    wait_until(m + 26 + LAT);
    drp(VA, 1'b0, 16'h0, 1'b1, 16'h5550);
    wait_until(m + 56);
    n = cyc;
    drp(CA, 1'b0, 16'h0, 1'b1, 16'hBEE0);
    wait_until(n + LAT + 2);

    // overlapping den: sticky error, single response, cleared by reset
    n = cyc;
    drp(CA, 1'b0, 16'h0, 1'b1, 16'hBEE0);
    step();
    probe(n + 3, P_ERR, 16'h1);
    probe(n + 12, P_ERR, 16'h1);
    drp(7'h00, 1'b0, 16'h0, 1'b0, 16'h0);
    wait_until(n + 13);
    rst = 1'b1;
    probe(cyc + 1, P_ERR, 16'h0);
    probe(cyc + 1, P_DO, 16'h0);
    step();
    rst = 1'b0;
    n = cyc;
    drp(VA, 1'b0, 16'h0, 1'b1, 16'h0000);
    wait_until(n + LAT + 2);

    // reset during CONV_I with a read outstanding, then a clean restart
    push(1'b0, 16'h1110, mv);
    push(1'b1, 16'h2220, m);
    expect_eoc(m + 27, VA[4:0], 1'b0);
    probe(m + 1, P_BUSY, 16'h1);
    probe(m + 41, P_CHAN, 16'h1C);
    wait_until(m + 30);
    drp(VA, 1'b0, 16'h0, 1'b1, 16'h1110);
    wait_until(m + 40);
    drp(CA, 1'b0, 16'h0, 1'b0, 16'h0);
    rst = 1'b1;
    reset_probes(m + 42);
    step();
    step();
    rst = 1'b0;
    probe(m + 43, P_TRV, 16'h1);
    probe(m + 43, P_TRI, 16'h1);
    wait_until(m + 70);
    push(1'b0, 16'h3330, mv);
    push(1'b1, 16'h4440, m);
    expect_seq(m);
    wait_until(m + 56);
    n = cyc;
    drp(VA, 1'b0, 16'h0, 1'b1, 16'h3330);
    wait_until(n + LAT);
    drp(CA, 1'b0, 16'h0, 1'b1, 16'h4440);
    wait_until(n + 2 * LAT + 2);

    // every queued expectation must have been met
    probe(cyc, P_DRPQ, 16'h0);
    probe(cyc, P_EOCQ, 16'h0);
    step();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
